// File: rtl/spart_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : spart_bus_arbiter_if
// Desc    : Requester handshake and SPART control/status signals of the arbiter.
// Rev     : 1.0
// ============================================================================
interface spart_bus_arbiter_if #(
   parameter int NREQ = 2
);
   logic              rda;
   logic              tbr;
   logic              iocs;
   logic              iorw;
   logic [1:0]        ioaddr;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   req_rw;
   logic [2*NREQ-1:0] req_addr;
   logic [8*NREQ-1:0] req_wdata;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   err;
   logic [7:0]        rdata;
   logic [NREQ-1:0]   rvalid;
   logic              cfg_busy;

   modport master (
      input  rda, tbr, req, req_rw, req_addr, req_wdata,
      output iocs, iorw, ioaddr, gnt, err, rdata, rvalid, cfg_busy
   );

   modport slave (
      output rda, tbr, req, req_rw, req_addr, req_wdata,
      input  iocs, iorw, ioaddr, gnt, err, rdata, rvalid, cfg_busy
   );
endinterface
`default_nettype wire

// File: rtl/spart_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spart_bus_arbiter
// Desc    : Round-robin owner of the SPART register bus; programs the baud
//           divisor after reset and whenever br_cfg changes.
// Rev     : 1.0
// ============================================================================
module spart_bus_arbiter #(
   parameter int NREQ = 2
) (
   input  wire              clk,
   input  wire              rst,
   input  wire [1:0]        br_cfg,
   inout  wire [7:0]        databus,
   spart_bus_arbiter_if.master bus
);

   localparam int IDX_W = (NREQ > 2) ? 2 : 1;

   typedef enum logic [2:0] {
      ST_CFG_LO = 3'd0,
      ST_CFG_HI = 3'd1,
      ST_ARB    = 3'd2,
      ST_XFER   = 3'd3,
      ST_GAP    = 3'd4
   } state_t;

   state_t            r_state;
   logic [1:0]        r_br_cfg_q;
   logic [IDX_W-1:0]  r_last;
   logic [IDX_W-1:0]  r_sel;
   logic              r_reject;
   logic [7:0]        r_rdata;
   logic [NREQ-1:0]   r_rvalid;

   logic [15:0]       w_divisor;
   logic [NREQ-1:0]   w_elig;
   logic [NREQ-1:0]   w_rej;
   logic              w_found;
   logic [IDX_W-1:0]  w_pick;
   logic [IDX_W-1:0]  w_cand;
   logic              w_sel_rw;
   logic [1:0]        w_sel_addr;
   logic [7:0]        w_sel_wdata;

   logic              w_iocs;
   logic              w_iorw;
   logic [1:0]        w_ioaddr;
   logic [7:0]        w_dout;
   logic              w_oe;
   logic [NREQ-1:0]   w_gnt;
   logic [NREQ-1:0]   w_err;
   logic              w_busy;

   always_comb begin
      case (r_br_cfg_q)
         2'b00:   w_divisor = 16'h028A;
         2'b01:   w_divisor = 16'h0145;
         2'b10:   w_divisor = 16'h00A2;
         default: w_divisor = 16'h0050;
      endcase
   end

   // Data-register accesses wait on SPART status; everything except a
   // status read is accepted immediately but rejected.
   always_comb begin
      w_elig = '0;
      w_rej  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req_addr[2*i +: 2] == 2'b00)
            w_elig[i] = bus.req[i] & (bus.req_rw[i] ? bus.rda : bus.tbr);
         else
            w_elig[i] = bus.req[i];
         w_rej[i] = (bus.req_addr[2*i +: 2] != 2'b00) &&
                    !((bus.req_addr[2*i +: 2] == 2'b01) && bus.req_rw[i]);
      end
   end

   // Scan from farthest to nearest so the requester closest to last+1 wins.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_last;
      w_cand  = r_last;
      for (int k = NREQ; k >= 1; k--) begin
         w_cand = IDX_W'((int'(r_last) + k) % NREQ);
         if (w_elig[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   assign w_sel_rw    = bus.req_rw[r_sel];
   assign w_sel_addr  = bus.req_addr[{r_sel, 1'b0} +: 2];
   assign w_sel_wdata = bus.req_wdata[{r_sel, 3'b000} +: 8];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_CFG_LO;
         r_br_cfg_q <= br_cfg;
         r_last     <= IDX_W'(NREQ - 1);
         r_sel      <= '0;
         r_reject   <= 1'b0;
         r_rdata    <= 8'h00;
         r_rvalid   <= '0;
      end else begin
         r_rvalid <= '0;
         case (r_state)
            ST_CFG_LO: r_state <= ST_CFG_HI;
            ST_CFG_HI: r_state <= ST_ARB;
            ST_ARB: begin
               if (br_cfg != r_br_cfg_q) begin
                  r_br_cfg_q <= br_cfg;
                  r_state    <= ST_CFG_LO;
               end else if (w_found) begin
                  r_sel    <= w_pick;
                  r_last   <= w_pick;
                  r_reject <= w_rej[w_pick];
                  r_state  <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (!r_reject && w_sel_rw) begin
                  r_rdata         <= databus;
                  r_rvalid[r_sel] <= 1'b1;
               end
               r_state <= ST_GAP;
            end
            ST_GAP:  r_state <= ST_ARB;
            default: r_state <= ST_CFG_LO;
         endcase
      end
   end

   // Bus outputs decode from registered state; rst forces the idle values.
   always_comb begin
      w_iocs   = 1'b0;
      w_iorw   = 1'b1;
      w_ioaddr = 2'b00;
      w_dout   = 8'h00;
      w_oe     = 1'b0;
      w_gnt    = '0;
      w_err    = '0;
      w_busy   = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_CFG_LO: begin
               w_iocs   = 1'b1;
               w_iorw   = 1'b0;
               w_ioaddr = 2'b10;
               w_dout   = w_divisor[7:0];
               w_oe     = 1'b1;
               w_busy   = 1'b1;
            end
            ST_CFG_HI: begin
               w_iocs   = 1'b1;
               w_iorw   = 1'b0;
               w_ioaddr = 2'b11;
               w_dout   = w_divisor[15:8];
               w_oe     = 1'b1;
               w_busy   = 1'b1;
            end
            ST_XFER: begin
               w_gnt[r_sel] = 1'b1;
               if (r_reject) begin
                  w_err[r_sel] = 1'b1;
               end else begin
                  w_iocs   = 1'b1;
                  w_iorw   = w_sel_rw;
                  w_ioaddr = w_sel_addr;
                  w_dout   = w_sel_wdata;
                  w_oe     = !w_sel_rw;
               end
            end
            default: ;
         endcase
      end
   end

   assign databus      = w_oe ? w_dout : 8'hzz;
   assign bus.iocs     = w_iocs;
   assign bus.iorw     = w_iorw;
   assign bus.ioaddr   = w_ioaddr;
   assign bus.gnt      = w_gnt;
   assign bus.err      = w_err;
   assign bus.cfg_busy = w_busy;
   assign bus.rdata    = r_rdata;
   assign bus.rvalid   = r_rvalid;

endmodule
`default_nettype wire

// File: doc/spart_bus_arbiter.md
Name: spart_bus_arbiter

Overview:
- Owns the SPART register bus (iocs/iorw/ioaddr/databus) and shares it between NREQ requesters using round-robin arbitration.
- Programs the baud divisor after reset and whenever br_cfg changes. This configuration takes priority over all requester traffic.
- Each requester transaction is gated on SPART status: tbr for TX writes, rda for RX reads. Requesters therefore never issue a bus cycle the SPART cannot accept.

Parameters:
- NREQ, 2: number of requesters (2..4).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400
- rda  input  1  SPART receive data available
- tbr  input  1  SPART transmit buffer ready
- iocs  output  1  SPART chip select
- iorw  output  1  1 = read (SPART->arbiter), 0 = write
- ioaddr  output  2  SPART register address
- databus  inout  8  SPART data bus; driven only when iocs=1 and iorw=0, otherwise Z
- req  input  NREQ  per-requester request; must be held stable, with its fields, until gnt
- req_rw  input  NREQ  per-requester direction (1 = read)
- req_addr  input  2*NREQ  per-requester address, packed; requester i uses bits [2i+1:2i]
- req_wdata  input  8*NREQ  per-requester write data, packed
- gnt  output  NREQ  one-cycle completion pulse to the chosen requester
- err  output  NREQ  one-cycle pulse with gnt when the request is rejected
- rdata  output  8  registered read data
- rvalid  output  NREQ  one-hot; high for one cycle, the cycle after gnt for a read
- cfg_busy  output  1  high while in CFG_LO or CFG_HI

Behaviour:
- Reset (rst=1 at posedge):
  - state <= CFG_LO; br_cfg_q <= br_cfg; last <= NREQ-1, so requester 0 has priority first; rdata <= 0; rvalid <= 0.
  - While rst=1, outputs are forced: iocs=0, iorw=1, ioaddr=00, gnt=0, err=0, cfg_busy=0, databus=Z.
- Divisor table (16-bit): 00 -> 0x028A, 01 -> 0x0145, 10 -> 0x00A2, 11 -> 0x0050. The value is indexed by br_cfg_q.
- States: CFG_LO, CFG_HI, ARB, XFER, GAP.
- CFG_LO:
  - Drives iocs=1, iorw=0, ioaddr=10, databus = divisor[7:0].
  - Always advances to CFG_HI.
- CFG_HI:
  - Drives iocs=1, iorw=0, ioaddr=11, databus = divisor[15:8].
  - Advances to ARB.
- ARB (iocs=0):
  - If br_cfg != br_cfg_q: load br_cfg_q <= br_cfg and go to CFG_LO. This check has priority over every pending request.
  - Otherwise, requester i is eligible when req[i]=1 and its access is allowed:
    - addr 00 write: requires tbr=1.
    - addr 00 read: requires rda=1.
    - addr 01 read (status): always eligible.
    - addr 01 write, or addr 1x: always eligible, but rejected.
  - Pick the first eligible requester searching from last+1 with wrap-around. Register it as sel, set last <= sel, go to XFER.
  - If no requester is eligible, stay in ARB. Ineligible requests wait indefinitely and are never dropped.
- XFER (exactly 1 cycle):
  - Normal request: iocs=1, iorw=req_rw[sel], ioaddr=req_addr[sel], databus=req_wdata[sel] if writing; gnt[sel]=1.
  - If reading, rdata <= databus and rvalid[sel] <= 1 at this clock edge.
  - Rejected request: iocs=0 and no bus cycle; gnt[sel]=1 and err[sel]=1.
  - Next state is GAP.
- GAP (1 cycle, iocs=0): lets the SPART update rda/tbr. Next state is ARB.
- Throughput: at most one grant every 3 cycles. Grant latency from the first cycle a request is eligible in ARB is 1 cycle to gnt.
- br_cfg change during XFER or GAP: the transaction completes normally; reconfiguration starts from the next ARB.
- br_cfg change during CFG_LO or CFG_HI: the current 2-byte sequence finishes with the latched value. The change is then seen in ARB, which re-enters CFG_LO.
- Reset mid-transaction: the in-flight transaction is abandoned (no gnt) and configuration restarts.
- rvalid is one-hot and is cleared on every cycle it is not set.

Test Plan:
- Reset with br_cfg=01 -> cycle 1: ioaddr=10, databus=0x45, iocs=1, iorw=0; cycle 2: ioaddr=11, databus=0x01; then iocs=0 in ARB.
- req[0] and req[1] both write addr 00 with tbr=1 held, 4 transactions each -> gnt alternates 0,1,0,1,...; grants are 3 cycles apart; databus matches each req_wdata.
- req[1] reads addr 00 with rda=0 for 10 cycles, then rda=1 and SPART drives 0x5A -> no bus cycle while rda=0; gnt[1] one cycle after rda rises; rdata=0x5A and rvalid=2'b10 on the following cycle.
- req[0] writes addr 10 -> gnt[0]=err[0]=1 for one cycle; iocs stays 0 throughout.
- With continuous traffic, change br_cfg 00->11 -> the current XFER completes, then ioaddr=10/0x50 and 11/0x00 are issued before any further grant; cfg_busy is high for exactly 2 cycles.
- Assert rst during XFER -> no gnt that cycle; outputs take their idle values; the CFG_LO/CFG_HI sequence restarts after rst falls.
